// File: rtl/sdm_link_ctrl.sv
// Link sequencer between the host sample streams and the sdm_tx / sdm_rx pair.
// One sample is in flight at a time: push to tx, wait for the rx echo, present it to the host.
module sdm_link_ctrl #(
  parameter int DMSB = 3,
  parameter int TOUT = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [DMSB:0]   s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [DMSB:0]   m_data,
  input  logic                   tx_empty,
  output logic                   tx_push,
  output logic signed [DMSB:0]   tx_wdata,
  output logic                   tx_clear,
  output logic                   rx_clear,
  input  logic                   rx_full,
  output logic                   rx_pop,
  input  logic signed [DMSB:0]   rx_rdata,
  output logic                   busy,
  output logic                   err,
  output logic [15:0]            count
);

  localparam int CW = (TOUT < 2) ? 1 : $clog2(TOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, PRESENT, ERR} state_t;

  state_t        state, state_nxt;
  logic          tx_empty_q, rx_full_q;
  logic          rx_rise, tout_hit;
  logic          accept, capture, expire, deliver;
  logic [CW-1:0] tout_cnt;

  assign rx_rise  = rx_full & ~rx_full_q;
  assign tout_hit = (tout_cnt == CW'(TOUT));
  assign busy     = (state != IDLE);

  // An rx rise in the same cycle as the timeout takes priority over the error.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = ARM;
      end
      ARM: begin
        s_ready = tx_empty_q;
        if (s_valid && tx_empty_q) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (rx_rise) begin
          capture   = 1'b1;
          state_nxt = PRESENT;
        end else if (tout_hit) begin
          expire    = 1'b1;
          state_nxt = ERR;
        end
      end
      PRESENT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          deliver   = 1'b1;
          state_nxt = en ? ARM : IDLE;
        end
      end
      ERR: begin
        if (!en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_empty_q <= 1'b0;
      rx_full_q  <= 1'b0;
      tout_cnt   <= '0;
      tx_push    <= 1'b0;
      tx_wdata   <= '0;
      rx_pop     <= 1'b0;
      m_data     <= '0;
      tx_clear   <= 1'b0;
      rx_clear   <= 1'b0;
      err        <= 1'b0;
      count      <= 16'd0;
    end else begin
      state      <= state_nxt;
      tx_empty_q <= tx_empty;
      rx_full_q  <= rx_full;
      tx_clear   <= 1'b0;
      rx_clear   <= 1'b0;
      if (accept) begin
        tx_wdata <= s_data;
        tx_push  <= ~tx_push;
        tout_cnt <= '0;
      end else if (state == WAIT && !capture && !expire) begin
        tout_cnt <= tout_cnt + CW'(1);
      end
      if (capture) begin
        m_data <= rx_rdata;
        rx_pop <= ~rx_pop;
      end
      // Clearing both converters drops whatever half-finished sample they still hold.
      if (expire) begin
        err      <= 1'b1;
        tx_clear <= 1'b1;
        rx_clear <= 1'b1;
      end
      if (state == ERR && !en) err <= 1'b0;
      if (deliver) count <= count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdm_link_ctrl.sv
// Directed bench for sdm_link_ctrl: instance a uses the default timeout, instance b a short one.
module tb_sdm_link_ctrl;
  localparam int DMSB = 3;

  logic clk = 1'b0;
  logic rst, en, s_valid, m_ready, tx_empty, rx_full;
  logic signed [DMSB:0] s_data, rx_rdata;

  logic a_s_ready, a_m_valid, a_tx_push, a_tx_clear, a_rx_clear, a_rx_pop, a_busy, a_err;
  logic signed [DMSB:0] a_m_data, a_tx_wdata;
  logic [15:0] a_count;
  logic b_s_ready, b_m_valid, b_tx_push, b_tx_clear, b_rx_clear, b_rx_pop, b_busy, b_err;
  logic signed [DMSB:0] b_m_data, b_tx_wdata;
  logic [15:0] b_count;

  int checks = 0;
  int passes = 0;
  logic [15:0] exp_count;
  int push_toggles = 0;
  int pop_toggles = 0;
  logic push_prev = 1'b0;
  logic pop_prev = 1'b0;

  always #5 clk = ~clk;

  sdm_link_ctrl #(.DMSB(DMSB)) u_a (
    .clk(clk), .rst(rst), .en(en),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
    .tx_empty(tx_empty), .tx_push(a_tx_push), .tx_wdata(a_tx_wdata),
    .tx_clear(a_tx_clear), .rx_clear(a_rx_clear),
    .rx_full(rx_full), .rx_pop(a_rx_pop), .rx_rdata(rx_rdata),
    .busy(a_busy), .err(a_err), .count(a_count)
  );

  sdm_link_ctrl #(.DMSB(DMSB), .TOUT(15)) u_b (
    .clk(clk), .rst(rst), .en(en),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
    .tx_empty(tx_empty), .tx_push(b_tx_push), .tx_wdata(b_tx_wdata),
    .tx_clear(b_tx_clear), .rx_clear(b_rx_clear),
    .rx_full(rx_full), .rx_pop(b_rx_pop), .rx_rdata(rx_rdata),
    .busy(b_busy), .err(b_err), .count(b_count)
  );

  // Toggle monitor for instance a, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (a_tx_push !== push_prev) push_toggles++;
    if (a_rx_pop !== pop_prev) pop_toggles++;
    push_prev = a_tx_push;
    pop_prev  = a_rx_pop;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic doReset();
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; m_ready = 1'b0; rx_full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic checkResetA();
    checkOutput("rst_tx_push", a_tx_push, 0);
    checkOutput("rst_rx_pop", a_rx_pop, 0);
    checkOutput("rst_tx_wdata", a_tx_wdata, 0);
    checkOutput("rst_m_data", a_m_data, 0);
    checkOutput("rst_m_valid", a_m_valid, 0);
    checkOutput("rst_s_ready", a_s_ready, 0);
    checkOutput("rst_tx_clear", a_tx_clear, 0);
    checkOutput("rst_rx_clear", a_rx_clear, 0);
    checkOutput("rst_err", a_err, 0);
    checkOutput("rst_busy", a_busy, 0);
    checkOutput("rst_count", a_count, 0);
  endtask

  // One full round trip on instance a: accept, echo after delay, hold m_ready low, handshake.
  task automatic applyStimulus(input logic signed [DMSB:0] d, input int delay, input int hold,
                               input bit drop_en);
    int n;
    logic exp_push, exp_pop;
    s_data = d; s_valid = 1'b1; n = 0;
    while (a_s_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    checkOutput("s_ready_wait", a_s_ready, 1);
    exp_push = ~a_tx_push;
    exp_pop  = ~a_rx_pop;
    @(negedge clk);
    s_valid = 1'b0; s_data = '0;
    if (drop_en) en = 1'b0;
    checkOutput("tx_push_toggle", a_tx_push, exp_push);
    checkOutput("tx_wdata", a_tx_wdata, d);
    checkOutput("s_ready_in_wait", a_s_ready, 0);
    repeat (delay) @(negedge clk);
    checkOutput("m_valid_early", a_m_valid, 0);
    rx_full = 1'b1; rx_rdata = d;
    @(negedge clk);
    checkOutput("m_valid", a_m_valid, 1);
    checkOutput("m_data", a_m_data, d);
    checkOutput("rx_pop_toggle", a_rx_pop, exp_pop);
    checkOutput("err_clear", a_err, 0);
    rx_full = 1'b0; rx_rdata = '0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_m_valid", a_m_valid, 1);
      checkOutput("hold_m_data", a_m_data, d);
      checkOutput("hold_s_ready", a_s_ready, 0);
      checkOutput("hold_tx_push", a_tx_push, exp_push);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    checkOutput("count", a_count, exp_count);
    checkOutput("m_valid_after", a_m_valid, 0);
    checkOutput("busy_after", a_busy, en);
  endtask

  initial begin
    int n;
    int sv;
    int push0, pop0;
    logic signed [DMSB:0] d;
    tx_empty = 1'b1; rx_rdata = '0; s_data = '0;
    doReset();
    checkResetA();
    checkOutput("rst_b_err", b_err, 0);

    // s_ready follows the registered tx_empty
    tx_empty = 1'b0; en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("arm_busy", a_busy, 1);
    checkOutput("arm_tx_full_s_ready", a_s_ready, 0);
    tx_empty = 1'b1;
    @(negedge clk);
    checkOutput("arm_s_ready", a_s_ready, 1);

    $display("[TB] single sample, back-pressure, en dropped in WAIT");
    applyStimulus(4'sd5, 40, 0, 1'b0);
    applyStimulus(-4'sd3, 5, 20, 1'b0);
    applyStimulus(4'sd6, 8, 2, 1'b1);

    $display("[TB] reset during WAIT");
    en = 1'b1; s_data = 4'sd4; s_valid = 1'b1; n = 0;
    while (a_s_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    checkOutput("mid_s_ready_wait", a_s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_busy", a_busy, 1);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 16'd0;
    checkResetA();
    rx_full = 1'b1; rx_rdata = 4'sd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_rst_m_valid", a_m_valid, 0);
      checkOutput("post_rst_busy", a_busy, 0);
    end
    rx_full = 1'b0;

    $display("[TB] timeout on short-limit instance");
    doReset();
    en = 1'b1; s_data = 4'sd2; s_valid = 1'b1; n = 0;
    while (b_s_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    checkOutput("b_s_ready_wait", b_s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("b_err_before", b_err, 0);
    checkOutput("b_tx_clear_before", b_tx_clear, 0);
    @(negedge clk);
    checkOutput("b_err_set", b_err, 1);
    checkOutput("b_tx_clear_pulse", b_tx_clear, 1);
    checkOutput("b_rx_clear_pulse", b_rx_clear, 1);
    checkOutput("b_err_s_ready", b_s_ready, 0);
    checkOutput("b_err_m_valid", b_m_valid, 0);
    checkOutput("b_err_busy", b_busy, 1);
    @(negedge clk);
    checkOutput("b_tx_clear_end", b_tx_clear, 0);
    checkOutput("b_rx_clear_end", b_rx_clear, 0);
    checkOutput("b_err_held", b_err, 1);
    en = 1'b0;
    @(negedge clk);
    checkOutput("b_err_cleared", b_err, 0);
    checkOutput("b_idle", b_busy, 0);

    $display("[TB] rx rise on the timeout cycle");
    en = 1'b1; s_data = -4'sd6; s_valid = 1'b1; n = 0;
    while (b_s_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    checkOutput("b2_s_ready_wait", b_s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (15) @(negedge clk);
    rx_full = 1'b1; rx_rdata = -4'sd6;
    @(negedge clk);
    checkOutput("b2_m_valid", b_m_valid, 1);
    checkOutput("b2_err", b_err, 0);
    checkOutput("b2_m_data", b_m_data, -4'sd6);
    checkOutput("b2_tx_clear", b_tx_clear, 0);
    rx_full = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checkOutput("b2_count", b_count, 1);

    $display("[TB] 300-sample sine stream");
    doReset();
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push0 = push_toggles;
    pop0  = pop_toggles;
    for (int i = 0; i < 300; i++) begin
      sv = $rtoi(7.0 * $sin(2.0 * 3.14159265 * i / 32.0));
      d  = sv[DMSB:0];
      applyStimulus(d, $urandom_range(1, 6), $urandom_range(0, 3), 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("stream_count", a_count, 16'd300);
    checkOutput("stream_push_toggles", push_toggles - push0, 300);
    checkOutput("stream_pop_toggles", pop_toggles - pop0, 300);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
